// File: rtl/fp32_uart_pkt_tx_if.sv
// Packet handshake bundle for the fp32 operand UART transmitter.
// The host (master) offers a packet with TX_VALID_I/TX_DATA_I and the
// transmitter (slave) answers with TX_READY_O.
interface fp32_uart_pkt_tx_if #(
   parameter int NUM_BYTES = 12
);
   logic                   TX_VALID_I;
   logic                   TX_READY_O;
   logic [8*NUM_BYTES-1:0] TX_DATA_I;

   modport master (
      output TX_VALID_I,
      output TX_DATA_I,
      input  TX_READY_O
   );

   modport slave (
      input  TX_VALID_I,
      input  TX_DATA_I,
      output TX_READY_O
   );
endinterface

// File: rtl/fp32_uart_pkt_tx.sv
// fp32_uart_pkt_tx: serialises one {acc, bravo, alpha} packet as NUM_BYTES
// 8N1 UART frames, byte 0 (TX_DATA_I[7:0]) first, each byte LSB first.
// Optional idle-high gap of GAP_BITS bit-times between bytes of a packet.
module fp32_uart_pkt_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int NUM_BYTES    = 12,
   parameter int GAP_BITS     = 0
) (
   input  logic              CLK_I,
   input  logic              RST_I,
   fp32_uart_pkt_tx_if.slave s_if,
   output logic              UART_TX_O,
   output logic              TX_BUSY_O,
   output logic              TX_DONE_O
);

   localparam int DATA_W = 8 * NUM_BYTES;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(1);
   localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [BAUD_W-1:0]   r_baud;
   logic [2:0]          r_bit;
   logic [BYTE_W-1:0]   r_byte;
   logic [GAP_W-1:0]    r_gap;
   logic [DATA_W-1:0]   r_shift;
   logic                r_line;
   logic                r_ready;
   logic                r_done;

   logic                w_accept;
   logic                w_baud_end;
   logic                w_line_next;
   logic                w_ready_next;
   logic                w_done_next;

   // r_ready is only ever high in IDLE, so it alone qualifies a transfer.
   assign w_accept   = s_if.TX_VALID_I & r_ready;
   assign w_baud_end = (r_baud == BAUD_LAST);

   // FSM state register
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: every non-idle state advances on a bit-time boundary
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_next = S_START;
         end
         S_START: begin
            if (w_baud_end) w_state_next = S_DATA;
         end
         S_DATA: begin
            if (w_baud_end && (r_bit == 3'd7)) w_state_next = S_STOP;
         end
         S_STOP: begin
            if (w_baud_end) begin
               if (r_byte < BYTE_LAST) begin
                  w_state_next = (GAP_BITS > 0) ? S_GAP : S_START;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (w_baud_end && (r_gap == GAP_LAST)) w_state_next = S_START;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state, so the registered line/ready/done
   // change on the same edge as the state they belong to.
   always_comb begin
      w_line_next = 1'b1;
      case (w_state_next)
         S_START: w_line_next = 1'b0;
         // r_shift[0] is the bit currently on the line; at a bit boundary
         // inside DATA the shift has not happened yet, so look one ahead.
         S_DATA:  w_line_next = ((r_state == S_DATA) && w_baud_end) ? r_shift[1] : r_shift[0];
         default: w_line_next = 1'b1;
      endcase
      w_ready_next = (w_state_next == S_IDLE);
      w_done_next  = (r_state == S_STOP) && (w_state_next == S_IDLE);
   end

   // Registered outputs keep the serial line glitch-free
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_line  <= 1'b1;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_line  <= w_line_next;
         r_ready <= w_ready_next;
         r_done  <= w_done_next;
      end
   end

   // Baud, bit, byte and gap counters; all parked at zero while idle
   always_ff @(posedge CLK_I) begin
      if (RST_I || (r_state == S_IDLE)) begin
         r_baud <= '0;
         r_bit  <= '0;
         r_byte <= '0;
         r_gap  <= '0;
      end else begin
         r_baud <= w_baud_end ? '0 : (r_baud + BAUD_ONE);
         if ((r_state == S_DATA) && w_baud_end) begin
            r_bit <= r_bit + 3'd1;
         end
         if ((r_state == S_STOP) && w_baud_end && (r_byte < BYTE_LAST)) begin
            r_byte <= r_byte + BYTE_ONE;
         end
         if ((r_state == S_GAP) && w_baud_end) begin
            r_gap <= (r_gap == GAP_LAST) ? '0 : (r_gap + GAP_ONE);
         end
      end
   end

   // Packet shift register: loaded on acceptance, shifted one bit per data
   // bit, so after each byte the next byte sits in the low 8 bits.
   always_ff @(posedge CLK_I) begin
      if (w_accept) begin
         r_shift <= s_if.TX_DATA_I;
      end else if ((r_state == S_DATA) && w_baud_end) begin
         r_shift <= r_shift >> 1;
      end
   end

   assign UART_TX_O       = r_line;
   assign s_if.TX_READY_O = r_ready;
   assign TX_BUSY_O       = (r_state != S_IDLE);
   assign TX_DONE_O       = r_done;

endmodule
